rs_reg_bank: RTL and testbench

RS_REG_BANK -- requirements
Module: rs_reg_bank

---
 rtl/rs_reg_bank.sv | 101 ++++++++++
 tb/tb_rs_reg_bank.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs_reg_bank.sv
// rs_reg_bank: bank of clocked SR channels with a selectable S=R=1 policy.
// Ports: C/CLR clock+async reset, EN, S/R requests, ERR_CLR; Q/Qn/CHG, CONFLICT/CONF_CNT status.
module rs_reg_bank #(
  parameter int WIDTH = 8,
  parameter int CONF_MODE = 0,
  parameter int CNT_W = 4,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             EN,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             ERR_CLR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] CHG,
  output logic             CONFLICT,
  output logic [CNT_W-1:0] CONF_CNT
);

  // Out-of-range policy codes fold onto hold.
  localparam int MODE =
    (CONF_MODE >= 0 && CONF_MODE <= 3) ? CONF_MODE : 0;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_chg;
  logic             r_conf;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_both;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_rst;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_conf_cyc;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_conf_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_both = S & R;
  assign w_set  = S & ~R;
  assign w_rst  = R & ~S;

  // Unambiguous requests applied; conflicting bits still hold r_q here.
  assign w_base = (r_q | w_set) & ~w_rst;

  always_comb begin
    w_q_nxt = w_base;
    case (MODE)
      1:       w_q_nxt = w_base | w_both;
      2:       w_q_nxt = w_base & ~w_both;
      3:       w_q_nxt = w_base ^ w_both;
      default: w_q_nxt = w_base;
    endcase
  end

  // Any number of conflicting channels in one cycle is one event.
  assign w_conf_cyc = EN & (|w_both);

  assign w_cnt_inc =
    (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  // A clear coincident with a new conflict restarts the count at 1.
  always_comb begin
    w_conf_nxt = r_conf;
    w_cnt_nxt  = r_cnt;
    if (ERR_CLR) begin
      w_conf_nxt = w_conf_cyc;
      w_cnt_nxt  = w_conf_cyc ? CNT_W'(1) : '0;
    end else if (w_conf_cyc) begin
      w_conf_nxt = 1'b1;
      w_cnt_nxt  = w_cnt_inc;
    end
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_q    <= INIT;
      r_chg  <= '0;
      r_conf <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (EN) begin
        r_q <= w_q_nxt;
      end
      r_chg  <= EN ? (w_q_nxt ^ r_q) : '0;
      r_conf <= w_conf_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign Q        = r_q;
  assign Qn       = ~r_q;
  assign CHG      = r_chg;
  assign CONFLICT = r_conf;
  assign CONF_CNT = r_cnt;

endmodule

// File: tb/tb_rs_reg_bank.sv
// tb_rs_reg_bank: directed vectors for rs_reg_bank across all S=R=1 policies.
// Instances 0-3: modes 0..3, INIT 0; 4: mode 3, INIT 1010; 5: mode 7, INIT 0.
module tb_rs_reg_bank;

  localparam int N = 6;

  logic       clk;
  logic       clr;
  logic       en;
  logic [3:0] s;
  logic [3:0] r;
  logic       ec;

  logic [3:0] q    [N];
  logic [3:0] qn   [N];
  logic [3:0] chg  [N];
  logic       conf [N];
  logic [3:0] cnt  [N];

  int nvec;
  int nerr;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int M =
      (g == 4) ? 3 : (g == 5) ? 7 : g;
    localparam logic [3:0] IV =
      (g == 4) ? 4'b1010 : 4'b0000;
    rs_reg_bank #(
      .WIDTH(4), .CONF_MODE(M),
      .CNT_W(4), .INIT(IV)
    ) u_dut (
      .C(clk), .CLR(clr), .EN(en),
      .S(s), .R(r), .ERR_CLR(ec),
      .Q(q[g]), .Qn(qn[g]), .CHG(chg[g]),
      .CONFLICT(conf[g]), .CONF_CNT(cnt[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            en;
    logic [3:0]      s;
    logic [3:0]      r;
    logic            ec;
    logic [3:0][3:0] eq;
    logic [3:0][3:0] ech;
    logic            ecf;
    logic [3:0]      ecn;
  } vec_t;

  function automatic vec_t mk(
    input logic en_i, input logic [3:0] s_i,
    input logic [3:0] r_i, input logic ec_i,
    input logic [15:0] q_i, input logic [15:0] c_i,
    input logic cf_i, input logic [3:0] cn_i);
    vec_t v;
    v.en  = en_i;
    v.s   = s_i;
    v.r   = r_i;
    v.ec  = ec_i;
    v.eq  = q_i;
    v.ech = c_i;
    v.ecf = cf_i;
    v.ecn = cn_i;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected Q per policy at fixed state, modes listed {m3,m2,m1,m0}.
  task automatic chk_q(input string nm, input logic [15:0] e);
    logic [3:0][3:0] ev;
    ev = e;
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("%s q%0d", nm, m), {4'b0, q[m]}, {4'b0, ev[m]});
      chk($sformatf("%s qn%0d", nm, m), {4'b0, qn[m]}, {4'b0, ~ev[m]});
    end
    chk($sformatf("%s q5", nm), {4'b0, q[5]}, {4'b0, ev[0]});
  endtask

  task automatic chk_st(input string nm,
                        input logic cf, input logic [3:0] cn);
    for (int g = 0; g < N; g++) begin
      chk($sformatf("%s conf%0d", nm, g), {7'b0, conf[g]}, {7'b0, cf});
      chk($sformatf("%s cnt%0d", nm, g), {4'b0, cnt[g]}, {4'b0, cn});
    end
  endtask

  vec_t tbl [14];

  initial begin
    nvec = 0;
    nerr = 0;
    clr = 1'b0;
    en  = 1'b0;
    s   = '0;
    r   = '0;
    ec  = 1'b0;

    //        en  s        r        ec  Q {m3,m2,m1,m0}            CHG {m3,m2,m1,m0}      cf cnt
    tbl[0]  = mk(1, 4'b0101, 4'b0000, 0, 16'b0101_0101_0101_0101, 16'b0101_0101_0101_0101, 0, 0);
    tbl[1]  = mk(1, 4'b0000, 4'b0000, 0, 16'b0101_0101_0101_0101, 16'h0000, 0, 0);
    tbl[2]  = mk(0, 4'b1111, 4'b0000, 0, 16'b0101_0101_0101_0101, 16'h0000, 0, 0);
    tbl[3]  = mk(0, 4'b1111, 4'b0000, 0, 16'b0101_0101_0101_0101, 16'h0000, 0, 0);
    tbl[4]  = mk(0, 4'b1111, 4'b0000, 0, 16'b0101_0101_0101_0101, 16'h0000, 0, 0);
    tbl[5]  = mk(1, 4'b0011, 4'b0011, 0, 16'b0110_0100_0111_0101, 16'b0011_0001_0010_0000, 1, 1);
    tbl[6]  = mk(1, 4'b0000, 4'b0101, 0, 16'b0010_0000_0010_0000, 16'b0100_0100_0101_0101, 1, 1);
    tbl[7]  = mk(1, 4'b0000, 4'b0000, 1, 16'b0010_0000_0010_0000, 16'h0000, 0, 0);
    tbl[8]  = mk(1, 4'b1000, 4'b1000, 0, 16'b1010_0000_1010_0000, 16'b1000_0000_1000_0000, 1, 1);
    tbl[9]  = mk(0, 4'b0000, 4'b0000, 1, 16'b1010_0000_1010_0000, 16'h0000, 0, 0);
    tbl[10] = mk(1, 4'b1111, 4'b0000, 0, 16'b1111_1111_1111_1111, 16'b0101_1111_0101_1111, 0, 0);
    tbl[11] = mk(1, 4'b1111, 4'b1111, 0, 16'b0000_0000_1111_1111, 16'b1111_1111_0000_0000, 1, 1);
    tbl[12] = mk(1, 4'b0000, 4'b0000, 0, 16'b0000_0000_1111_1111, 16'h0000, 1, 1);
    tbl[13] = mk(0, 4'b1111, 4'b1111, 0, 16'b0000_0000_1111_1111, 16'h0000, 1, 1);

    // Asynchronous reset, no clock edge yet.
    #1 clr = 1'b1;
    #1;
    for (int g = 0; g < N; g++) begin
      logic [3:0] iv;
      iv = (g == 4) ? 4'b1010 : 4'b0000;
      chk($sformatf("rst q%0d", g), {4'b0, q[g]}, {4'b0, iv});
      chk($sformatf("rst qn%0d", g), {4'b0, qn[g]}, {4'b0, ~iv});
      chk($sformatf("rst chg%0d", g), {4'b0, chg[g]}, 8'h0);
    end
    chk_st("rst", 1'b0, 4'd0);

    // Inputs are ignored across an edge while CLR is held.
    en = 1'b1;
    s  = 4'b1111;
    r  = 4'b0011;
    ec = 1'b0;
    tick();
    chk("rsthold q0", {4'b0, q[0]}, 8'h00);
    chk("rsthold q4", {4'b0, q[4]}, 8'h0a);
    chk("rsthold chg0", {4'b0, chg[0]}, 8'h00);
    chk_st("rsthold", 1'b0, 4'd0);
    #1 clr = 1'b0;

    for (int i = 0; i < 14; i++) begin
      en = tbl[i].en;
      s  = tbl[i].s;
      r  = tbl[i].r;
      ec = tbl[i].ec;
      tick();
      chk_q($sformatf("v%0d", i), tbl[i].eq);
      for (int m = 0; m < 4; m++)
        chk($sformatf("v%0d chg%0d", i, m),
            {4'b0, chg[m]}, {4'b0, tbl[i].ech[m]});
      chk($sformatf("v%0d chg5", i),
          {4'b0, chg[5]}, {4'b0, tbl[i].ech[0]});
      chk_st($sformatf("v%0d", i), tbl[i].ecf, tbl[i].ecn);
    end

    // 20 conflict cycles on bit 0: count saturates at 15.
    en = 1'b1;
    s  = 4'b0001;
    r  = 4'b0001;
    ec = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("sat%0d cnt", k), {4'b0, cnt[0]},
          8'((1 + k > 15) ? 15 : 1 + k));
    end
    chk_st("sat", 1'b1, 4'd15);
    chk_q("sat", 16'b0000_0000_1111_1111);

    // Clear with no conflict: status drops, Q untouched.
    s  = 4'b0000;
    r  = 4'b0000;
    ec = 1'b1;
    tick();
    chk_st("eclr", 1'b0, 4'd0);
    chk_q("eclr", 16'b0000_0000_1111_1111);

    // Seven conflicts, then clear coincident with a conflict.
    s  = 4'b0001;
    r  = 4'b0001;
    ec = 1'b0;
    repeat (7) tick();
    chk_st("cnt7", 1'b1, 4'd7);
    chk("cnt7 q3", {4'b0, q[3]}, 8'h01);
    ec = 1'b1;
    tick();
    chk_st("eclr+conf", 1'b1, 4'd1);
    chk("eclr+conf q3", {4'b0, q[3]}, 8'h00);
    chk("eclr+conf chg3", {4'b0, chg[3]}, 8'h01);

    // CLR between edges while a CHG pulse is live.
    ec = 1'b0;
    s  = 4'b1111;
    r  = 4'b0000;
    #3 clr = 1'b1;
    #1;
    chk("midclr q4", {4'b0, q[4]}, 8'h0a);
    chk("midclr qn4", {4'b0, qn[4]}, 8'h05);
    chk("midclr chg4", {4'b0, chg[4]}, 8'h00);
    chk("midclr chg3", {4'b0, chg[3]}, 8'h00);
    chk("midclr q0", {4'b0, q[0]}, 8'h00);
    chk_st("midclr", 1'b0, 4'd0);
    tick();
    chk("clrhold q4", {4'b0, q[4]}, 8'h0a);
    chk("clrhold chg4", {4'b0, chg[4]}, 8'h00);

    // First edge after release processes inputs normally.
    #1 clr = 1'b0;
    s = 4'b0001;
    r = 4'b0000;
    tick();
    chk("post q4", {4'b0, q[4]}, 8'h0b);
    chk("post chg4", {4'b0, chg[4]}, 8'h01);
    chk("post q0", {4'b0, q[0]}, 8'h01);
    chk("post chg0", {4'b0, chg[0]}, 8'h01);
    chk_st("post", 1'b0, 4'd0);
    s = 4'b0000;
    tick();
    chk("post2 chg4", {4'b0, chg[4]}, 8'h00);
    chk("post2 q4", {4'b0, q[4]}, 8'h0b);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
